// File: rtl/apb_uart_if.sv
// APB3 slave in front of uart_top's FIFOs: DATA/STATUS/CTRL/CLEAR registers, sticky errors.
// Define APB_UART_IRQ_EN to build the CTRL register and the level interrupt; otherwise irq=0.
module apb_uart_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDR_W-1:0]    paddr,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic                 tx_fifo_wr_en,
    output logic [DATA_BITS-1:0] tx_fifo_din,
    input  logic                 tx_fifo_full,
    output logic                 rx_fifo_rd_en,
    input  logic [DATA_BITS-1:0] rx_fifo_dout,
    input  logic                 rx_fifo_empty,
    input  logic                 rx_error,
    output logic                 irq
);

    typedef enum logic [1:0] {IDLE, POP, CAPT, RESP} state_e;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_CLEAR  = 2'd3;

    state_e               state_q, state_d;
    logic [31:0]          prdata_q, prdata_d;
    logic                 pslverr_q, pslverr_d;
    logic                 wr_en_q, wr_en_d;
    logic [DATA_BITS-1:0] din_q, din_d;
    logic                 rx_err_q, rx_err_d;
    logic                 tx_ovf_q, tx_ovf_d;
    logic                 pop_req, set_ovf, clr_rx, clr_ovf;

`ifdef APB_UART_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q;
`endif

    logic       access, setup, bad_addr;
    logic [1:0] reg_sel;
    logic       unused_ok;

    assign access    = psel & penable;
    assign setup     = psel & ~penable;
    assign reg_sel   = paddr[3:2];
    assign bad_addr  = |paddr[ADDR_W-1:4];
    assign unused_ok = ^{paddr[1:0], pwdata[31:DATA_BITS]};

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        wr_en_d   = 1'b0;
        din_d     = din_q;
        pop_req   = 1'b0;
        set_ovf   = 1'b0;
        clr_rx    = 1'b0;
        clr_ovf   = 1'b0;
`ifdef APB_UART_IRQ_EN
        ctrl_d    = ctrl_q;
`endif
        unique case (state_q)
            IDLE: begin
                // A non-empty DATA read pops in setup so the byte is ready one cycle later.
                if (setup && !pwrite && !bad_addr && reg_sel == REG_DATA && !rx_fifo_empty) begin
                    pop_req = 1'b1;
                    state_d = POP;
                end else if (access) begin
                    state_d   = RESP;
                    prdata_d  = '0;
                    pslverr_d = 1'b0;
                    if (bad_addr) begin
                        pslverr_d = 1'b1;
                    end else if (pwrite) begin
                        unique case (reg_sel)
                            REG_DATA: begin
                                if (tx_fifo_full) begin
                                    pslverr_d = 1'b1;
                                    set_ovf   = 1'b1;
                                end else begin
                                    wr_en_d = 1'b1;
                                    din_d   = pwdata[DATA_BITS-1:0];
                                end
                            end
`ifdef APB_UART_IRQ_EN
                            REG_CTRL:  ctrl_d = pwdata[1:0];
`endif
                            REG_CLEAR: begin
                                clr_rx  = pwdata[2];
                                clr_ovf = pwdata[3];
                            end
                            default: ;
                        endcase
                    end else begin
                        unique case (reg_sel)
                            // Reaching here means RX was empty at setup.
                            REG_DATA:   pslverr_d = 1'b1;
                            REG_STATUS: prdata_d  = 32'({tx_ovf_q, rx_err_q, rx_fifo_empty, tx_fifo_full});
`ifdef APB_UART_IRQ_EN
                            REG_CTRL:   prdata_d  = 32'(ctrl_q);
`endif
                            default: ;
                        endcase
                    end
                end
            end
            POP:  state_d = CAPT;
            CAPT: begin
                state_d   = RESP;
                prdata_d  = 32'(rx_fifo_dout);
                pslverr_d = 1'b0;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new error on the same cycle as its clear stays set.
        rx_err_d = rx_error | (rx_err_q & ~clr_rx);
        tx_ovf_d = set_ovf  | (tx_ovf_q & ~clr_ovf);
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            wr_en_q   <= 1'b0;
            din_q     <= '0;
            rx_err_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            wr_en_q   <= wr_en_d;
            din_q     <= din_d;
            rx_err_q  <= rx_err_d;
            tx_ovf_q  <= tx_ovf_d;
        end
    end

`ifdef APB_UART_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= (ctrl_q[0] & ~rx_fifo_empty) | (ctrl_q[1] & (rx_err_q | tx_ovf_q));
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign prdata        = prdata_q;
    assign pslverr       = pslverr_q;
    assign pready        = (state_q == RESP);
    assign tx_fifo_wr_en = wr_en_q;
    assign tx_fifo_din   = din_q;
    // Gated so no pop can be issued while reset is held.
    assign rx_fifo_rd_en = pop_req & rst_n;

endmodule
